// File: rtl/lsu_rmw_if.sv
// rtl/lsu_rmw_if.sv - request/response and data-memory signal bundle for lsu_rmw
interface lsu_rmw_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_wr_en, mem_addr, mem_wr_data
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_wr_en, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - load/store unit with read-modify-write for byte and half stores
module lsu_rmw #(
    parameter int MEM_SIZE = 512
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_rmw_if.slave  bus
);
    localparam logic [31:0] MEM_WORDS = 32'(MEM_SIZE);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wr_data_q;

    logic        req_fire;
    logic        bad_f3;
    logic        misalign;
    logic        out_of_range;
    logic        req_err;
    logic [4:0]  lane_sh;
    logic [31:0] rd_shift;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign req_fire        = bus.req_valid && (state == IDLE);
    assign bus.req_ready   = (state == IDLE);
    assign bus.resp_valid  = (state == RESP);
    assign bus.mem_wr_en   = (state == WR);
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;

    // Classify the incoming request: illegal width code, misalignment, or beyond memory.
    always_comb begin
        bad_f3       = bus.req_we ? (bus.req_funct3 > 3'd2)
                                  : ((bus.req_funct3 == 3'd3) || (bus.req_funct3[2:1] == 2'b11));
        misalign     = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3 == 3'd2) && (bus.req_addr[1:0] != 2'b00));
        out_of_range = {2'b00, bus.req_addr[31:2]} >= MEM_WORDS;
        req_err      = bad_f3 || misalign || out_of_range;
    end

    // Lane extraction for loads and lane merge for sub-word stores, both from the RD read word.
    always_comb begin
        lane_sh  = {lat_off, 3'b000};
        rd_shift = bus.mem_rd_data >> lane_sh;
        case (lat_funct3)
            3'd0:    load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_val = {24'd0, rd_shift[7:0]};
            3'd5:    load_val = {16'd0, rd_shift[15:0]};
            default: load_val = bus.mem_rd_data;
        endcase
        lane_mask = (lat_funct3 == 3'd0) ? (32'h0000_00ff << lane_sh) : (32'h0000_ffff << lane_sh);
        merged    = (bus.mem_rd_data & ~lane_mask) | ((lat_wdata << lane_sh) & lane_mask);
    end

    // State register; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: errors skip memory, word stores skip the read, sub-word stores read then write.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (req_err)                       state_nxt = RESP;
                    else if (!bus.req_we)              state_nxt = RD;
                    else if (bus.req_funct3 == 3'd2)   state_nxt = WR;
                    else                               state_nxt = RD;
                end
            end
            RD:      state_nxt = lat_we ? WR : RESP;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, memory address/data registers and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we        <= 1'b0;
            lat_funct3    <= 3'd0;
            lat_off       <= 2'd0;
            lat_wdata     <= 32'd0;
            resp_rdata_q  <= 32'd0;
            resp_err_q    <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wr_data_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        lat_we       <= bus.req_we;
                        lat_funct3   <= bus.req_funct3;
                        lat_off      <= bus.req_addr[1:0];
                        lat_wdata    <= bus.req_wdata;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= req_err;
                        if (!req_err) begin
                            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                            if (bus.req_we && (bus.req_funct3 == 3'd2))
                                mem_wr_data_q <= bus.req_wdata;
                        end
                    end
                end
                RD: begin
                    if (lat_we) mem_wr_data_q <= merged;
                    else        resp_rdata_q  <= load_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - scoreboard bench for lsu_rmw against a byte-array memory model
module tb_lsu_rmw;
    localparam int MEM_SIZE = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    lsu_rmw_if bus();

    lsu_rmw #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory seen by the DUT
    logic [31:0] mem [MEM_SIZE];
    assign bus.mem_rd_data = mem[bus.mem_addr[10:2]];
    always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr[10:2]] <= bus.mem_wr_data;

    // Reference memory, byte addressed
    logic [7:0] ref_bytes [MEM_SIZE*4];

    typedef struct { bit err; logic [31:0] rdata; int cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
    endfunction

    // RV32I load/store semantics on a flat byte array
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output bit err, output logic [31:0] rd, output int lat,
                         output bit wr, output logic [31:0] waddr, output logic [31:0] wword);
        int size;
        bit sgn;
        logic [31:0] v;
        logic signed [31:0] t;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        sgn   = !f3[2];
        err   = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        err   = err || (f3[1:0] == 2'd3) || (a % size != 0) || ((a >> 2) >= MEM_SIZE);
        rd    = 32'd0;
        wr    = 1'b0;
        waddr = 32'd0;
        wword = 32'd0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            v = 32'd0;
            for (int k = 0; k < size; k++) v = v | (32'(ref_bytes[int'(a) + k]) << (8 * k));
            if (sgn) begin
                t  = $signed(v << (32 - 8 * size));
                rd = t >>> (32 - 8 * size);
            end else begin
                rd = v;
            end
            lat = 2;
        end else begin
            for (int k = 0; k < size; k++) ref_bytes[int'(a) + k] = wd[8*k +: 8];
            lat   = (size == 4) ? 2 : 3;
            wr    = 1'b1;
            waddr = a & ~32'd3;
            wword = ref_word(int'(waddr));
        end
    endtask

    // Drive a request; while the block is busy, hold valid high with junk fields.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit use_model);
        int n;
        bit err, wr;
        logic [31:0] rd, waddr, wword;
        int lat;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            bus.req_valid  = 1'b1;
            bus.req_we     = 1'($urandom);
            bus.req_funct3 = 3'($urandom);
            bus.req_addr   = $urandom;
            bus.req_wdata  = $urandom;
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        if (use_model) begin
            model(we, f3, a, wd, err, rd, lat, wr, waddr, wword);
            resp_q.push_back('{err, rd, cyc + lat});
            if (wr) wr_q.push_back('{waddr, wword, cyc + lat - 1});
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT responds or writes memory
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 32'(bus.resp_valid), 32'd0);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.mem_wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 32'(bus.mem_wr_en), 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", bus.mem_addr, w.addr);
                    chk("wr_data", bus.mem_wr_data, w.data);
                    chk("wr_cycle", 32'(cyc), 32'(w.cyc));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] <= (i == 4) ? 32'h8899_aabb : (i * 32'h0101_0107) ^ 32'h5a3c_96e1;
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < MEM_SIZE; i++) begin
            a = (i == 4) ? 32'h8899_aabb : (i * 32'h0101_0107) ^ 32'h5a3c_96e1;
            for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = a[8*k +: 8];
        end
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_wr_data", bus.mem_wr_data, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 3'd0, 32'h12, 32'h0, 1'b1);          // LB  -> ffffff99
        issue(1'b0, 3'd5, 32'h12, 32'h0, 1'b1);          // LHU -> 00008899
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);          // LW  -> 8899aabb
        issue(1'b1, 3'd0, 32'h11, 32'h1234_56cc, 1'b1);  // SB  -> 8899ccbb
        issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 3'd2, 32'h06, 32'h0, 1'b1);          // misaligned LW
        issue(1'b1, 3'd2, 32'h800, 32'hdead_beef, 1'b1); // out-of-range SW
        issue(1'b1, 3'd2, 32'h7fc, 32'hcafe_f00d, 1'b1); // last word
        issue(1'b0, 3'd4, 32'h7ff, 32'h0, 1'b1);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                @(negedge clk);
            end
            issue(1'($urandom), 3'($urandom), ra, $urandom, 1'b1);
        end

        // Reset in the middle of a half-word read-modify-write
        issue(1'b1, 3'd1, 32'h20, 32'h0000_7e7e, 1'b0);
        @(posedge clk);
        #1;
        chk("abort_wr_en_before", 32'(bus.mem_wr_en), 32'd1);
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("abort_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_mem_addr", bus.mem_addr, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_mem_kept", mem[8], ref_word(32));
        rst_n = 1'b1;
        issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);

        for (int n = 0; n < 20 && (resp_q.size() != 0 || wr_q.size() != 0); n++) @(negedge clk);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
